// File: rtl/register_file.sv
// register_file
//
// Architectural register file for the single-issue MIPS datapath.
// Two combinational read ports (rs/rt) for decode, one synchronous write
// port fed by the write-register select mux, and one debug read port.
// Register 0 is hard-wired to zero. A same-cycle write-to-read bypass
// lets decode see the value being written back in the same cycle.
//
// Ports:
//   clk        in   sole clock, state updates on the rising edge
//   rst        in   asynchronous, active-high reset (clears all entries)
//   RegWrite   in   write enable for the current cycle
//   writeReg   in   destination index
//   writeData  in   write-back value
//   readReg1   in   read port 1 index (rs)
//   readReg2   in   read port 2 index (rt)
//   readData1  out  read port 1 value (combinational, bypassed)
//   readData2  out  read port 2 value (combinational, bypassed)
//   dbgReg     in   debug inspection index
//   dbgData    out  stored value at dbgReg (combinational, no bypass)
//
// Handshake: there is none. The write port is a plain enable; the producer
// holds RegWrite/writeReg/writeData stable around the rising edge and the
// write is committed at that edge if RegWrite=1, writeReg!=0 and rst=0.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic [ADDR_WIDTH-1:0] dbgReg,
  output logic [DATA_WIDTH-1:0] dbgData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // A write to index 0 is dropped here, so entry 0 stays at its reset
  // value of zero; the read paths force zero for index 0 as well.
  logic writeEn;
  assign writeEn = RegWrite && (writeReg != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[writeReg] <= writeData;
    end
  end

  // Bypass is checked against the raw RegWrite/writeReg pair and ignores
  // rst: during reset storage is zero but an in-flight write-back value is
  // still forwarded to decode.
  logic bypass1;
  logic bypass2;
  assign bypass1 = RegWrite && (writeReg == readReg1);
  assign bypass2 = RegWrite && (writeReg == readReg2);

  always_comb begin
    readData1 = regs[readReg1];
    if (readReg1 == '0) begin
      readData1 = '0;
    end else if (bypass1) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = regs[readReg2];
    if (readReg2 == '0) begin
      readData2 = '0;
    end else if (bypass2) begin
      readData2 = writeData;
    end
  end

  // Debug port shows committed state only, so a write appears one edge later.
  always_comb begin
    dbgData = regs[dbgReg];
    if (dbgReg == '0) begin
      dbgData = '0;
    end
  end

endmodule
